tt_um_hoene_protocol_tracker: RTL
=================================

# tt_um_hoene_protocol_tracker

Parametrised frame tracker for the serial LED stream, operating in the global `clk` domain on pre-synchronised strobes. It counts bits and LED words inside a frame, captures the word addressed to this device, and forwards the stream one cycle later with that word passed, removed or replaced. It enters test mode when the LED count saturates. It sits between the input synchroniser and the LED driver / output pins.

## Interface
Parameters:
- `BITS_PER_LED`, default 32: bits per LED word; must be ≥ 2 and need not be a power of two.
- `LED_CNT_W`, default 12: width of the LED word counter and the index.
- `BIT_CNT_W`, default `$clog2(BITS_PER_LED)`: width of the bit counter. Derived; do not override.

Ports:
- `clk`  in  1  global clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_clk`  in  1  bit strobe; high for exactly one `clk` cycle per stream bit.
- `in_data`  in  1  stream bit, valid when `in_clk` is high.
- `in_sync`  in  1  frame active; low means between frames.
- `sel_index`  in  LED_CNT_W  index of the LED word owned by this device.
- `mode`  in  2  forwarding mode: 0 PASS, 1 CONSUME, 2 REPLACE, 3 reserved (behaves as PASS).
- `replace_word`  in  BITS_PER_LED  word inserted in REPLACE mode, sent MSB first.
- `bit_counter`  out  BIT_CNT_W  bit position within the current word.
- `led_counter`  out  LED_CNT_W  index of the current word.
- `test_mode`  out  1  LED count saturated in this frame.
- `led_word`  out  BITS_PER_LED  last completely captured own word.
- `led_valid`  out  1  one-cycle pulse marking a `led_word` update.
- `out_data`  out  1  forwarded data, registered.
- `out_clk`  out  1  forwarded strobe, registered.

## Operation
- Reset (`rst_n` low, asynchronous): all outputs and internal registers go to 0, and the FSM goes to IDLE.
- FSM states: IDLE, RUN, SAT.
  - Any state goes to IDLE whenever `in_sync` is low. This is a synchronous clear of `bit_counter`, `led_counter`, `test_mode`, `out_*`, `led_valid` and the capture shift register.
  - `led_word` is not cleared by this; it holds its value.
  - While in IDLE, `sel_index` and `mode` are latched every cycle. They are frozen while `in_sync` is high.
  - IDLE goes to RUN on the first cycle with `in_sync` high.
- RUN, on each strobe:
  - `bit_counter` increments.
  - At `BITS_PER_LED-1`, `bit_counter` wraps to 0 and `led_counter` increments.
  - If `led_counter` is all-ones at a word end, it holds, `test_mode` goes to 1 and the FSM enters SAT.
- Capture: when latched index equals `led_counter` in RUN, strobed `in_data` is shifted in MSB first. On the final bit, `led_word` takes the shift register contents plus this bit, and `led_valid` pulses.
- Forwarding while `in_sync` is high:
  - `out_clk` follows `in_clk`, except where CONSUME gates it.
  - PASS: `out_data` = `in_data`.
  - CONSUME: during the own word, `out_clk` and `out_data` are forced 0, which removes the word from the stream.
  - REPLACE: during the own word, `out_data` = `replace_word[BITS_PER_LED-1-bit_counter]`; the strobe is passed through.
- SAT: counters hold, capture is disabled, forwarding is PASS regardless of mode, and `test_mode` stays 1 until `in_sync` goes low.
- `in_clk` while `in_sync` is low is ignored.
- A frame aborted mid-word (`in_sync` falls) produces no `led_valid`, and `led_word` keeps its previous value.

## Timing
- `out_data` / `out_clk`: exactly 1 cycle latency from `in_data` / `in_clk`.
- Counters update on the edge that samples the strobe.
- `led_word` and `led_valid` are registered on the edge sampling the final bit of the own word. `led_valid` is high for that single following cycle.
- `test_mode` rises on the edge sampling the last bit of word index 2^LED_CNT_W − 1.
- `in_sync` low takes effect on the next edge and has priority over a coincident strobe.

## Structure
- Shared package `tt_um_hoene_protocol_pkg` holds:
  - mode constants `MODE_PASS`, `MODE_CONSUME`, `MODE_REPLACE`;
  - FSM state encoding IDLE/RUN/SAT.
- Sub-module `tt_um_hoene_word_shifter` (parameter `BITS_PER_LED`) covers MSB-first shift-in, a load-on-last-bit output register and `led_valid` generation. It is enabled by the parent's own-word qualifier and cleared by `in_sync` low.
- Counters, FSM and the forwarding mux stay in the top module.

## Test plan
- Reset: assert `rst_n` low mid-frame with strobes active. All outputs go to 0 immediately, without waiting for a clock edge.
- Capture: defaults, `sel_index`=2, PASS, 4 words with word 2 = 0xA5C3_0F81. `led_word`=0xA5C3_0F81 with one `led_valid` pulse. The output stream equals the input stream delayed by 1 cycle. Final `led_counter`=4.
- CONSUME: `sel_index`=0, 3 words. `out_clk` pulses 64 times (words 1–2 only), and no `out_clk` appears during word 0.
- REPLACE: `sel_index`=1, `replace_word`=0xDEAD_BEEF. The forwarded word 1 reads 0xDEAD_BEEF; words 0 and 2 are unchanged.
- Saturation: `LED_CNT_W`=2, `BITS_PER_LED`=8, 6 words, REPLACE. `test_mode` rises at the last bit of word 3. Words 4–5 pass unmodified, and `led_counter` holds 3.
- Abort and mode change: drop `in_sync` at bit 10 of the own word and change `mode` while `in_sync` is high. There is no `led_valid`, `led_word` keeps its old value, and the new mode applies only to the next frame.

Source files
------------

// File: rtl/tt_um_hoene_protocol_pkg.sv
// Shared definitions for the serial LED stream frame tracker.
// Holds the forwarding mode constants and the tracker FSM state encoding.
// No ports; imported by the tracker top and its word shifter.
package tt_um_hoene_protocol_pkg;

  // Forwarding modes; the fourth encoding is reserved and treated as pass.
  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_CONSUME = 2'd1;
  localparam logic [1:0] MODE_REPLACE = 2'd2;

  // Tracker FSM: waiting for a frame, counting words, or saturated.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

endpackage

// File: rtl/tt_um_hoene_word_shifter.sv
// MSB-first capture of the LED word addressed to this device.
// Ports:
//   clk, rst_n   global clock, asynchronous active-low reset
//   clear        synchronous clear of the shift register and valid pulse
//   enable       strobed bit belongs to the own word
//   last         current bit is the final bit of the word
//   bit_in       stream bit
//   led_word     last completely captured word (held across frames)
//   led_valid    one-cycle pulse when led_word is updated
module tt_um_hoene_word_shifter
  import tt_um_hoene_protocol_pkg::*;
#(
  parameter int BITS_PER_LED = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    last,
  input  logic                    bit_in,
  output logic [BITS_PER_LED-1:0] led_word,
  output logic                    led_valid
);

  logic [BITS_PER_LED-2:0] shift_reg;
  logic [BITS_PER_LED-1:0] shifted;

  // The incoming bit completes the word together with the bits collected so
  // far, so only BITS_PER_LED-1 bits ever need to be stored.
  assign shifted = {shift_reg, bit_in};

  // Shift on every own-word strobe and load the output register on the final
  // bit. A frame abort clears the partial word but leaves led_word untouched,
  // so a truncated word never reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      led_word  <= '0;
      led_valid <= 1'b0;
    end else if (clear) begin
      shift_reg <= '0;
      led_valid <= 1'b0;
    end else begin
      led_valid <= enable && last;
      if (enable) begin
        shift_reg <= shifted[BITS_PER_LED-2:0];
        if (last) begin
          led_word <= shifted;
        end
      end
    end
  end

endmodule

// File: rtl/tt_um_hoene_protocol_tracker.sv
// Frame tracker for the serial LED stream. Counts bits and words inside a
// frame, captures the own word and forwards the stream one cycle later with
// the own word passed, removed or replaced. Saturating the word counter puts
// the block into test mode for the rest of the frame.
// Ports:
//   clk, rst_n                 global clock, asynchronous active-low reset
//   in_clk, in_data, in_sync   synchronised bit strobe, bit, frame active
//   sel_index, mode            own word index and forwarding mode (latched in IDLE)
//   replace_word               word sent MSB first in place of the own word
//   bit_counter, led_counter   position within the frame
//   test_mode                  word counter saturated in this frame
//   led_word, led_valid        captured own word and its update pulse
//   out_data, out_clk          registered forwarded stream
module tt_um_hoene_protocol_tracker
  import tt_um_hoene_protocol_pkg::*;
#(
  parameter int BITS_PER_LED = 32,
  parameter int LED_CNT_W    = 12,
  parameter int BIT_CNT_W    = $clog2(BITS_PER_LED)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_clk,
  input  logic                    in_data,
  input  logic                    in_sync,
  input  logic [LED_CNT_W-1:0]    sel_index,
  input  logic [1:0]              mode,
  input  logic [BITS_PER_LED-1:0] replace_word,
  output logic [BIT_CNT_W-1:0]    bit_counter,
  output logic [LED_CNT_W-1:0]    led_counter,
  output logic                    test_mode,
  output logic [BITS_PER_LED-1:0] led_word,
  output logic                    led_valid,
  output logic                    out_data,
  output logic                    out_clk
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_LED - 1);

  state_t                  state;
  state_t                  state_next;
  logic [LED_CNT_W-1:0]    sel_q;
  logic [1:0]              mode_q;
  logic                    strobe;
  logic                    word_end;
  logic                    led_max;
  logic                    own_word;
  logic                    fwd_clk;
  logic                    fwd_data;
  logic [BITS_PER_LED-1:0] replace_rev;

  assign word_end = (bit_counter == LAST_BIT);
  assign led_max  = &led_counter;
  assign strobe   = in_sync && in_clk && (state == ST_RUN);
  assign own_word = (state == ST_RUN) && (sel_q == led_counter);

  // Bit-reversed copy so the replacement bit can be picked directly with the
  // bit counter while still sending the word MSB first.
  always_comb begin
    replace_rev = '0;
    for (int i = 0; i < BITS_PER_LED; i++) begin
      replace_rev[i] = replace_word[BITS_PER_LED-1-i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and forwarding mux. Dropping in_sync always returns to
  // IDLE. Only RUN can produce an own word, so SAT forwards as pass.
  always_comb begin
    state_next = state;
    fwd_clk    = in_clk;
    fwd_data   = in_data;
    case (state)
      ST_IDLE: state_next = ST_RUN;
      ST_RUN:  if (strobe && word_end && led_max) state_next = ST_SAT;
      ST_SAT:  state_next = ST_SAT;
      default: state_next = ST_IDLE;
    endcase
    if (!in_sync) begin
      state_next = ST_IDLE;
    end
    if (own_word) begin
      case (mode_q)
        MODE_CONSUME: begin
          fwd_clk  = 1'b0;
          fwd_data = 1'b0;
        end
        MODE_REPLACE: fwd_data = replace_rev[bit_counter];
        default: ;
      endcase
    end
  end

  // Index and mode follow the inputs only between frames, so a change during
  // a frame takes effect on the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      mode_q <= MODE_PASS;
    end else if (state == ST_IDLE) begin
      sel_q  <= sel_index;
      mode_q <= mode;
    end
  end

  // Frame counters, test mode flag and registered forwarding. On saturation
  // the bit counter still wraps but the word counter holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_counter <= '0;
      led_counter <= '0;
      test_mode   <= 1'b0;
      out_clk     <= 1'b0;
      out_data    <= 1'b0;
    end else if (!in_sync) begin
      bit_counter <= '0;
      led_counter <= '0;
      test_mode   <= 1'b0;
      out_clk     <= 1'b0;
      out_data    <= 1'b0;
    end else begin
      out_clk  <= fwd_clk;
      out_data <= fwd_data;
      if (strobe) begin
        if (word_end) begin
          bit_counter <= '0;
          if (led_max) begin
            test_mode <= 1'b1;
          end else begin
            led_counter <= led_counter + LED_CNT_W'(1);
          end
        end else begin
          bit_counter <= bit_counter + BIT_CNT_W'(1);
        end
      end
    end
  end

  tt_um_hoene_word_shifter #(
    .BITS_PER_LED(BITS_PER_LED)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!in_sync),
    .enable   (strobe && own_word),
    .last     (word_end),
    .bit_in   (in_data),
    .led_word (led_word),
    .led_valid(led_valid)
  );

endmodule
